// File: rtl/ttt_pkg.sv
// ttt_pkg: shared codes for the tic-tac-toe turn sequencer.
// Holds square, cell, outcome, turn and state encodings plus board helpers.
package ttt_pkg;

    localparam int NUM_SQ  = 9;
    localparam int BOARD_W = 2 * NUM_SQ;

    typedef enum logic [3:0] {
        SQ_NONE = 4'd0,
        A1      = 4'd1,
        A2      = 4'd2,
        A3      = 4'd3,
        B1      = 4'd4,
        B2      = 4'd5,
        B3      = 4'd6,
        C1      = 4'd7,
        C2      = 4'd8,
        C3      = 4'd9
    } square_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        IN_PROGRESS = 2'b00,
        WIN         = 2'b01,
        LOSE        = 2'b10,
        TIE         = 2'b11
    } outcome_t;

    typedef enum logic [1:0] {
        TURN_NONE = 2'b00,
        TURN_P1   = 2'b01,
        TURN_P2   = 2'b10
    } turn_t;

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_USER_1 = 3'd1,
        ST_USER_2 = 3'd2,
        ST_CHECK  = 3'd3,
        ST_END    = 3'd4
    } state_t;

    function automatic logic sq_valid(logic [3:0] mv);
        return (mv != SQ_NONE) && (mv <= C3);
    endfunction

    // Out-of-range codes read back as EMPTY; callers gate with sq_valid.
    function automatic cell_t cell_at(logic [BOARD_W-1:0] b,
                                      logic [3:0] mv);
        cell_t c;
        c = EMPTY;
        for (int i = 0; i < NUM_SQ; i++) begin
            if (mv == 4'(i + 1)) c = cell_t'(b[2*i +: 2]);
        end
        return c;
    endfunction

    function automatic logic [BOARD_W-1:0] put_cell(
        logic [BOARD_W-1:0] b,
        logic [3:0]         mv,
        cell_t              c
    );
        logic [BOARD_W-1:0] r;
        r = b;
        for (int i = 0; i < NUM_SQ; i++) begin
            if (mv == 4'(i + 1)) r[2*i +: 2] = c;
        end
        return r;
    endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// turn_sequencer_if: move requests in, acks/board/turn/outcome out.
// master = input decode side, slave = turn_sequencer.
interface turn_sequencer_if;
    import ttt_pkg::*;

    logic               start;
    logic               p1_req;
    logic [3:0]         p1_move;
    logic               p2_req;
    logic [3:0]         p2_move;
    logic               p1_ack;
    logic               p2_ack;
    logic               reject;
    logic [BOARD_W-1:0] board;
    logic [1:0]         turn;
    logic [1:0]         outcome;

    modport master (
        output start, p1_req, p1_move, p2_req, p2_move,
        input  p1_ack, p2_ack, reject, board, turn, outcome
    );

    modport slave (
        input  start, p1_req, p1_move, p2_req, p2_move,
        output p1_ack, p2_ack, reject, board, turn, outcome
    );

endinterface

// File: rtl/turn_sequencer_win_detect.sv
// win_detect: combinational three-in-a-row check for both players.
// Looks at all 3 rows, 3 columns and both diagonals.
module win_detect
    import ttt_pkg::*;
(
    input  logic [BOARD_W-1:0] board,
    output logic               p1_line,
    output logic               p2_line
);

    function automatic logic has_line(logic [BOARD_W-1:0] b,
                                      cell_t who);
        logic [NUM_SQ-1:0] m;
        for (int i = 0; i < NUM_SQ; i++) begin
            m[i] = (b[2*i +: 2] == who);
        end
        return (&m[2:0]) | (&m[5:3]) | (&m[8:6])
             | (m[0] & m[3] & m[6])
             | (m[1] & m[4] & m[7])
             | (m[2] & m[5] & m[8])
             | (m[0] & m[4] & m[8])
             | (m[2] & m[4] & m[6]);
    endfunction

    assign p1_line = has_line(board, P1);
    assign p2_line = has_line(board, P2);

endmodule

// File: rtl/turn_sequencer.sv
// turn_sequencer: grants the board to one player per turn, commits moves.
// Optional TURN_TIMEOUT_EN forfeits an idle turn after TIMEOUT_CYCLES.
module turn_sequencer
    import ttt_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int CNT_W          = 26
) (
    input  logic            clk,
    input  logic            rst,
    turn_sequencer_if.slave bus
);

    if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cnt_w_check
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    state_t             state_q, state_n;
    logic [BOARD_W-1:0] board_q, board_n;
    outcome_t           outcome_q, outcome_n;
    logic [3:0]         count_q, count_n;
    logic               mover_p1_q, mover_p1_n;
    logic               p1_ack_q, p1_ack_n;
    logic               p2_ack_q, p2_ack_n;
    logic               reject_q, reject_n;

    logic               p1_line, p2_line;
    logic               in_user, is_p1;
    logic               own_req, own_ok;
    logic [3:0]         own_move;
    logic               timeout;

    win_detect u_win (
        .board   (board_q),
        .p1_line (p1_line),
        .p2_line (p2_line)
    );

    // Only the turn owner's request is ever looked at.
    assign in_user  = (state_q == ST_USER_1) || (state_q == ST_USER_2);
    assign is_p1    = (state_q == ST_USER_1);
    assign own_req  = is_p1 ? bus.p1_req  : bus.p2_req;
    assign own_move = is_p1 ? bus.p1_move : bus.p2_move;
    assign own_ok   = own_req && sq_valid(own_move)
                   && (cell_at(board_q, own_move) == EMPTY);

`ifdef TURN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] timer_q, timer_n;

    assign timeout = in_user && (timer_q == TMO_LAST);

    always_comb begin
        timer_n = '0;
        if (in_user && (state_n == state_q)) begin
            timer_n = timer_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) timer_q <= '0;
        else      timer_q <= timer_n;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n    = state_q;
        board_n    = board_q;
        outcome_n  = outcome_q;
        count_n    = count_q;
        mover_p1_n = mover_p1_q;
        p1_ack_n   = 1'b0;
        p2_ack_n   = 1'b0;
        reject_n   = 1'b0;
        unique case (state_q)
            ST_START: begin
                if (bus.start) state_n = ST_USER_1;
            end
            ST_USER_1, ST_USER_2: begin
                if (own_ok) begin
                    board_n    = put_cell(board_q, own_move,
                                          is_p1 ? P1 : P2);
                    count_n    = count_q + 4'd1;
                    mover_p1_n = is_p1;
                    p1_ack_n   = is_p1;
                    p2_ack_n   = !is_p1;
                    state_n    = ST_CHECK;
                end else begin
                    reject_n = own_req || timeout;
                    if (timeout) begin
                        state_n = is_p1 ? ST_USER_2 : ST_USER_1;
                    end
                end
            end
            ST_CHECK: begin
                if (p1_line) begin
                    outcome_n = WIN;
                    state_n   = ST_END;
                end else if (p2_line) begin
                    outcome_n = LOSE;
                    state_n   = ST_END;
                end else if (count_q == 4'd9) begin
                    outcome_n = TIE;
                    state_n   = ST_END;
                end else begin
                    state_n = mover_p1_q ? ST_USER_2 : ST_USER_1;
                end
            end
            ST_END: begin
                state_n = ST_END;
            end
            default: begin
                state_n = ST_START;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_START;
            board_q    <= '0;
            outcome_q  <= IN_PROGRESS;
            count_q    <= '0;
            mover_p1_q <= 1'b0;
            p1_ack_q   <= 1'b0;
            p2_ack_q   <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_n;
            board_q    <= board_n;
            outcome_q  <= outcome_n;
            count_q    <= count_n;
            mover_p1_q <= mover_p1_n;
            p1_ack_q   <= p1_ack_n;
            p2_ack_q   <= p2_ack_n;
            reject_q   <= reject_n;
        end
    end

    assign bus.board   = board_q;
    assign bus.outcome = outcome_q;
    assign bus.p1_ack  = p1_ack_q;
    assign bus.p2_ack  = p2_ack_q;
    assign bus.reject  = reject_q;
    assign bus.turn    = (state_q == ST_USER_1) ? TURN_P1
                       : (state_q == ST_USER_2) ? TURN_P2
                       : TURN_NONE;

endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed and random games against a game-level model.
// The model tracks the board as an array and applies the game rules directly.
module tb_turn_sequencer;
    import ttt_pkg::*;

    logic clk;
    logic rst;

    turn_sequencer_if bus ();

    turn_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    int mb [9];
    int owner;
    int mover;
    int moves;
    int outc;
    bit over;

    bit         r1, r2;
    logic [3:0] m1, m2;

    function automatic logic [17:0] pack_board();
        logic [17:0] r;
        for (int i = 0; i < 9; i++) r[2*i +: 2] = 2'(mb[i]);
        return r;
    endfunction

    function automatic int winner();
        for (int p = 1; p <= 2; p++) begin
            for (int i = 0; i < 3; i++) begin
                if (mb[3*i] == p && mb[3*i+1] == p && mb[3*i+2] == p)
                    return p;
                if (mb[i] == p && mb[i+3] == p && mb[i+6] == p)
                    return p;
            end
            if (mb[0] == p && mb[4] == p && mb[8] == p) return p;
            if (mb[2] == p && mb[4] == p && mb[6] == p) return p;
        end
        return 0;
    endfunction

    function automatic logic [1:0] exp_turn();
        if (over || owner == 0) return 2'b00;
        return 2'(owner);
    endfunction

    function automatic logic [3:0] rnd_move();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(1, 9));
    endfunction

    task automatic chk(input string tag, input logic [17:0] obs,
                       input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input bit a1,
                              input bit a2, input bit rj);
        chk({tag, ".p1_ack"},  18'(bus.p1_ack),  18'(a1));
        chk({tag, ".p2_ack"},  18'(bus.p2_ack),  18'(a2));
        chk({tag, ".reject"},  18'(bus.reject),  18'(rj));
        chk({tag, ".board"},   bus.board,        pack_board());
        chk({tag, ".turn"},    18'(bus.turn),    18'(exp_turn()));
        chk({tag, ".outcome"}, 18'(bus.outcome), 18'(outc));
    endtask

    task automatic clear_inputs();
        bus.start   = 1'b0;
        bus.p1_req  = 1'b0;
        bus.p1_move = 4'd0;
        bus.p2_req  = 1'b0;
        bus.p2_move = 4'd0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) mb[i] = 0;
        owner = 0;
        mover = 0;
        moves = 0;
        outc  = 0;
        over  = 1'b0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
        model_reset();
        check_outs("reset", 0, 0, 0);
    endtask

    task automatic start_game();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        if (!over && owner == 0) owner = 1;
        check_outs("start", 0, 0, 0);
    endtask

    task automatic drive(input bit q1, input logic [3:0] v1,
                         input bit q2, input logic [3:0] v2,
                         input string tag);
        bit a1, a2, rj, committed, r;
        int m, w;
        bus.p1_req  = q1;
        bus.p1_move = v1;
        bus.p2_req  = q2;
        bus.p2_move = v2;
        step();
        a1 = 0; a2 = 0; rj = 0; committed = 0;
        if (!over && owner != 0) begin
            r = (owner == 1) ? q1 : q2;
            m = (owner == 1) ? int'(v1) : int'(v2);
            if (r && m >= 1 && m <= 9 && mb[m-1] == 0) begin
                mb[m-1] = owner;
                moves++;
                committed = 1;
                if (owner == 1) a1 = 1;
                else            a2 = 1;
            end else if (r) begin
                rj = 1;
            end
        end
        if (committed) begin
            mover = owner;
            owner = 0;
        end
        check_outs(tag, a1, a2, rj);
        if (committed) begin
            bus.p1_req = 1'b0;
            bus.p2_req = 1'b0;
            step();
            w = winner();
            if (w == 1) begin
                outc = 1; over = 1;
            end else if (w == 2) begin
                outc = 2; over = 1;
            end else if (moves == 9) begin
                outc = 3; over = 1;
            end else begin
                owner = (mover == 1) ? 2 : 1;
            end
            check_outs({tag, ".check"}, 0, 0, 0);
        end
    endtask

    task automatic play(input int p, input int sq, input string tag);
        if (p == 1) drive(1, 4'(sq), 0, 4'd0, tag);
        else        drive(0, 4'd0, 1, 4'(sq), tag);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();

        reset_dut();
        play(1, 1, "start_req_ignored");
        start_game();
        play(1, 1, "win.p1_1");
        play(2, 4, "win.p2_4");
        play(1, 2, "win.p1_2");
        play(2, 5, "win.p2_5");
        play(1, 3, "win.p1_3");
        chk("win_row", 18'(bus.board[5:0]), 18'(6'b010101));
        chk("win_outcome", 18'(bus.outcome), 18'(2'b01));
        play(2, 6, "win.end_p2");
        bus.start = 1'b1;
        play(1, 7, "win.end_start");
        bus.start = 1'b0;

        reset_dut();
        start_game();
        play(1, 5, "occ.p1_5");
        play(2, 5, "occ.p2_5");
        play(2, 1, "occ.p2_1");

        reset_dut();
        start_game();
        play(1, 0, "bad.mv0");
        play(1, 12, "bad.mv12");
        play(1, 15, "bad.held1");
        play(1, 15, "bad.held2");
        play(2, 3, "bad.p2_only");

        reset_dut();
        start_game();
        play(1, 1, "tie.1");
        play(2, 2, "tie.2");
        play(1, 3, "tie.3");
        play(2, 5, "tie.4");
        play(1, 4, "tie.5");
        play(2, 6, "tie.6");
        play(1, 8, "tie.7");
        play(2, 7, "tie.8");
        play(1, 9, "tie.9");
        chk("tie_outcome", 18'(bus.outcome), 18'(2'b11));
        drive(1, 4'd1, 1, 4'd2, "tie.end_both");
        drive(1, 4'd0, 1, 4'd14, "tie.end_bad");

        reset_dut();
        start_game();
        drive(1, 4'd7, 1, 4'd3, "simul");
        chk("simul_sq3", 18'(bus.board[5:4]), 18'(2'b00));

        reset_dut();
        start_game();
        bus.p1_req  = 1'b1;
        bus.p1_move = 4'd5;
        step();
        chk("midrst.ack", 18'(bus.p1_ack), 18'(1'b1));
        chk("midrst.board", bus.board, 18'h00100);
        clear_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
        model_reset();
        check_outs("midrst.clear", 0, 0, 0);
        play(1, 5, "midrst.start_wait");

        for (int g = 0; g < 40; g++) begin
            reset_dut();
            start_game();
            for (int k = 0; k < 100 && !over; k++) begin
                r1 = ($urandom_range(0, 2) != 0);
                r2 = ($urandom_range(0, 2) != 0);
                m1 = rnd_move();
                m2 = rnd_move();
                drive(r1, m1, r2, m2, "rand");
            end
            drive(1, rnd_move(), 1, rnd_move(), "rand.tail");
        end

        clear_inputs();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
